// File: rtl/stopwatch_pkg.sv
// Shared types and seven-segment patterns for the stopwatch display path.
// Segment vectors are active-low and ordered {g,f,e,d,c,b,a}.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DASH  = 7'b0111111;

  // Patterns for the decimal digits 0..9, indexed by digit value.
  localparam seg_t SEG_DIGITS [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bus between the BCD counter (master) and the scan driver (slave).
// Handshake: none. The digits are level signals, sampled by the slave only at
// the end of each full scan. The display outputs are registered levels.
// dbg_idx exposes the digit slot that is currently being scanned.
interface seg7_scan_driver_if;
  import stopwatch_pkg::*;

  logic       blank;
  bcd_t       d1;
  bcd_t       d2;
  bcd_t       d3;
  bcd_t       d4;
  logic [3:0] an;
  seg_t       seg;
  logic       dp;
  logic [1:0] dbg_idx;

  modport master (output blank, d1, d2, d3, d4,
                  input  an, seg, dp, dbg_idx);
  modport slave  (input  blank, d1, d2, d3, d4,
                  output an, seg, dp, dbg_idx);
endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder.
// Codes 10..15 are not valid BCD and are shown as a dash.
module bcd_to_7seg
  import stopwatch_pkg::*;
(
  input  bcd_t i_bcd,
  output seg_t o_seg
);

  // Look up the digit pattern, falling back to a dash for illegal codes.
  always_comb begin
    o_seg = SEG_DASH;
    if (i_bcd <= 4'd9) begin
      o_seg = SEG_DIGITS[i_bcd];
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit time-multiplexed seven-segment driver. One digit slot lasts
// REFRESH_DIV clocks. All four digits are captured together at the end of a
// full scan so a counter carry ripple is never displayed half-updated.
module seg7_scan_driver
  import stopwatch_pkg::*;
#(
  parameter int         REFRESH_DIV = 100_000,
  parameter logic [3:0] DP_MASK     = 4'b0100,
  parameter int         LZ_BLANK    = 1
) (
  input  logic               clk,
  input  logic               reset,
  seg7_scan_driver_if.slave  bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [15:0]      r_snap;  // {d4,d3,d2,d1}
  logic [3:0]       r_an;
  seg_t             r_seg;
  logic             r_dp;

  logic             w_tick;
  bcd_t             w_digit;
  logic             w_digit_blank;
  seg_t             w_seg;

  assign w_tick = (r_cnt == CNT_LAST);

  // Prescaler, slot index and end-of-scan digit snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_idx  <= 2'd0;
      r_snap <= 16'h0000;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
      if (r_idx == 2'd3) begin
        r_snap <= {bus.d4, bus.d3, bus.d2, bus.d1};
      end
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Select the snapshot digit for the current slot and decide leading-zero blanking.
  always_comb begin
    w_digit       = r_snap[3:0];
    w_digit_blank = 1'b0;
    case (r_idx)
      2'd0: w_digit = r_snap[3:0];
      2'd1: w_digit = r_snap[7:4];
      2'd2: begin
        w_digit       = r_snap[11:8];
        w_digit_blank = (LZ_BLANK != 0) && (r_snap[15:8] == 8'h00);
      end
      default: begin
        w_digit       = r_snap[15:12];
        w_digit_blank = (LZ_BLANK != 0) && (r_snap[15:12] == 4'h0);
      end
    endcase
  end

  bcd_to_7seg u_dec (
    .i_bcd (w_digit),
    .o_seg (w_seg)
  );

  // Register the display lines so they change one clock after the slot index.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else if (bus.blank || w_digit_blank) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= w_seg;
      r_dp  <= ~DP_MASK[r_idx];
    end
  end

  assign bus.an      = r_an;
  assign bus.seg     = r_seg;
  assign bus.dp      = r_dp;
  assign bus.dbg_idx = r_idx;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with REFRESH_DIV=4, DP_MASK=4'b0100, LZ_BLANK=1.
// A reference model derived from elapsed time since reset predicts the display
// every cycle; a few directed checks pin down the documented slot contents.
module tb_seg7_scan_driver;

  localparam int         DIV = 4;
  localparam logic [3:0] DPM = 4'b0100;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  logic chk_en = 1'b0;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(
    .REFRESH_DIV (DIV),
    .DP_MASK     (DPM),
    .LZ_BLANK    (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [6:0] ref_pattern(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Returns {an, seg, dp} for a slot given the captured digits and blank input.
  function automatic logic [11:0] ref_display(input int slot, input logic [15:0] snap,
                                              input logic blk);
    logic [3:0] digit;
    logic       dark;
    logic [3:0] an;
    digit = snap[slot*4 +: 4];
    dark  = blk || (slot == 3 && snap[15:12] == 4'h0) || (slot == 2 && snap[15:8] == 8'h00);
    if (dark) return {4'b1111, 7'h7F, 1'b1};
    an = 4'b1111;
    an[slot] = 1'b0;
    return {an, ref_pattern(digit), ~DPM[slot]};
  endfunction

  int          m_t = 0;        // clock edges since reset released
  logic [15:0] m_snap = 16'h0;
  logic [3:0]  e_an = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1;
  logic [1:0]  e_idx = 2'd0;

  // Predict what the outputs hold after each rising edge.
  always @(posedge clk) begin
    if (reset) begin
      m_t    <= 0;
      m_snap <= 16'h0;
      e_an   <= 4'b1111;
      e_seg  <= 7'h7F;
      e_dp   <= 1'b1;
      e_idx  <= 2'd0;
    end else begin
      {e_an, e_seg, e_dp} <= ref_display((m_t / DIV) % 4, m_snap, bus.blank);
      if ((m_t % DIV) == DIV - 1 && ((m_t / DIV) % 4) == 3)
        m_snap <= {bus.d4, bus.d3, bus.d2, bus.d1};
      m_t   <= m_t + 1;
      e_idx <= 2'(((m_t + 1) / DIV) % 4);
    end
  end

  // Scoreboard: compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("an",  32'(bus.an),      32'(e_an));
      check("seg", 32'(bus.seg),     32'(e_seg));
      check("dp",  32'(bus.dp),      32'(e_dp));
      check("idx", 32'(bus.dbg_idx), 32'(e_idx));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_digits(input logic [15:0] v);
    {bus.d4, bus.d3, bus.d2, bus.d1} = v;
  endtask

  // Wait (bounded) until the model says the given slot is being scanned.
  task automatic wait_slot(input int slot);
    int guard;
    guard = 0;
    while (((m_t / DIV) % 4) != slot && guard < 64) begin
      run_cycles(1);
      guard++;
    end
    check("wait_slot_timeout", 32'(guard < 64), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  logic [3:0]  t2_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0]  t2_seg [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
  logic        t2_dp  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    reset     = 1'b1;
    bus.blank = 1'b0;
    set_digits(16'h1234);

    // 1. reset held three cycles: outputs stay dark
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    run_cycles(2);
    check("rst_an", 32'(bus.an), 32'hF);
    reset = 1'b0;

    // 2. 1,2,3,4 over two scans; second scan shows the captured digits
    run_cycles(17);
    for (int s = 0; s < 4; s++) begin
      check("t2_an",  32'(bus.an),  32'(t2_an[s]));
      check("t2_seg", 32'(bus.seg), 32'(t2_seg[s]));
      check("t2_dp",  32'(bus.dp),  32'(t2_dp[s]));
      run_cycles(4);
    end

    // 3. leading zeros 0,0,0,7
    set_digits(16'h0007);
    run_cycles(40);

    // 4. change d1 4 -> 5 during slot 1
    set_digits(16'h1234);
    run_cycles(32);
    wait_slot(1);
    bus.d1 = 4'd5;
    run_cycles(36);

    // 5. illegal code on d1 shows a dash
    bus.d1 = 4'hC;
    run_cycles(36);

    // 6. blank mid-scan, then reset during slot 2
    wait_slot(1);
    run_cycles(1);
    bus.blank = 1'b1;
    run_cycles(10);
    bus.blank = 1'b0;
    run_cycles(20);
    wait_slot(2);
    reset = 1'b1;
    run_cycles(1);
    check("t6_rst_an",  32'(bus.an),      32'hF);
    check("t6_rst_idx", 32'(bus.dbg_idx), 32'd0);
    reset = 1'b0;
    run_cycles(20);

    // random phase
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        bus.d1 = 4'($urandom_range(0, 15));
        bus.d2 = 4'($urandom_range(0, 15));
        bus.d3 = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(0, 15));
        bus.d4 = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 19) == 0) bus.blank = ~bus.blank;
      reset = ($urandom_range(0, 99) == 0);
      run_cycles(1);
    end
    reset = 1'b0;
    bus.blank = 1'b0;
    run_cycles(4);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
